// File: rtl/rx_uart_frame_engine_pkg.sv
// rx_uart_frame_engine_pkg: shared parity encodings, Rx FSM state type and parity check helper.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

package rx_uart_frame_engine_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // data_xor is the XOR of all received data bits; pbit is the received parity bit.
  function automatic logic parity_fail(input int mode, input logic data_xor, input logic pbit);
    case (mode)
      PARITY_EVEN: return data_xor ^ pbit;
      PARITY_ODD:  return ~(data_xor ^ pbit);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_uart_frame_engine_if.sv
// rx_uart_frame_engine_if: received-word valid/ready handshake with per-word error flags.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

interface rx_uart_frame_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  parity_error;
  logic                  framing_error;
  logic                  overrun_error;

  modport master (
    output rx_data, rx_valid, parity_error, framing_error, overrun_error,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_error, framing_error, overrun_error,
    output rx_ready
  );
endinterface

`default_nettype wire

// File: rtl/rx_uart_frame_engine_sampler.sv
// rx_uart_frame_engine_sampler: tick divider, bit-phase counter and 3-sample majority vote.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module rx_uart_frame_engine_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int CLK_DIV    = 1
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic enable,
  input  wire logic serial,
  output logic      bit_valid,
  output logic      bit_value,
  output logic      phase_wrap
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = $clog2(OVERSAMPLE);
  localparam int MID   = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_S0    = PH_W'(MID - 1);
  localparam logic [PH_W-1:0]  PH_S1    = PH_W'(MID);
  localparam logic [PH_W-1:0]  PH_S2    = PH_W'(MID + 1);

  logic [DIV_W-1:0] div_cnt;
  logic [PH_W-1:0]  phase;
  logic             samp0;
  logic             samp1;
  logic             tick;

  assign tick = enable && (div_cnt == DIV_LAST);

  // Counters are held at zero while disabled so a new frame always starts at phase 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      phase   <= '0;
      samp0   <= 1'b0;
      samp1   <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      phase   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
        if (phase == PH_S0) samp0 <= serial;
        if (phase == PH_S1) samp1 <= serial;
      end
    end
  end

  // The third sample is the live line value on the resolving tick.
  assign bit_valid  = tick && (phase == PH_S2);
  assign bit_value  = (samp0 & samp1) | (samp0 & serial) | (samp1 & serial);
  assign phase_wrap = tick && (phase == PH_LAST);

endmodule

`default_nettype wire

// File: rtl/rx_uart_frame_engine.sv
// rx_uart_frame_engine: parametrised UART receive FSM, shift register, error flags and output handshake.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module rx_uart_frame_engine
  import rx_uart_frame_engine_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int CLK_DIV     = 1,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic serial_in_synced,
  output logic      busy,
  rx_uart_frame_engine_if.master rx
);

  localparam int               BIT_W     = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  rx_state_t state;
  rx_state_t next_state;

  logic                  line_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  data_xor;
  logic                  pbit;
  logic                  ferr_acc;
  logic                  commit_pend;

  logic                  data_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  oerr_q;

  logic bit_valid;
  logic bit_value;
  logic phase_wrap;

  logic start_frame;
  logic shift_en;
  logic par_en;
  logic stop_vote;
  logic bit_inc;
  logic stop_inc;
  logic frame_done;

  rx_uart_frame_engine_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .CLK_DIV    (CLK_DIV)
  ) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .enable     (state != ST_IDLE),
    .serial     (serial_in_synced),
    .bit_valid  (bit_valid),
    .bit_value  (bit_value),
    .phase_wrap (phase_wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_vote   = 1'b0;
    bit_inc     = 1'b0;
    stop_inc    = 1'b0;
    frame_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (line_q && !serial_in_synced) begin
          next_state  = ST_START;
          start_frame = 1'b1;
        end
      end
      ST_START: begin
        // The vote precedes the wrap, so reaching the wrap implies a valid start bit.
        if (bit_valid && bit_value) next_state = ST_IDLE;
        else if (phase_wrap)        next_state = ST_DATA;
      end
      ST_DATA: begin
        shift_en = bit_valid;
        if (phase_wrap) begin
          if (bit_cnt == BIT_LAST)
            next_state = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          else
            bit_inc = 1'b1;
        end
      end
      ST_PARITY: begin
        par_en = bit_valid;
        if (phase_wrap) next_state = ST_STOP;
      end
      ST_STOP: begin
        if (bit_valid) begin
          stop_vote = 1'b1;
          // Leave on the final vote rather than the bit end so the next start edge is not missed.
          if (stop_cnt == STOP_LAST) begin
            next_state = ST_IDLE;
            frame_done = 1'b1;
          end
        end else if (phase_wrap) begin
          stop_inc = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q      <= 1'b0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      shreg       <= '0;
      data_xor    <= 1'b0;
      pbit        <= 1'b0;
      ferr_acc    <= 1'b0;
      commit_pend <= 1'b0;
    end else begin
      line_q      <= serial_in_synced;
      commit_pend <= frame_done;
      if (start_frame) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        data_xor <= 1'b0;
        pbit     <= 1'b0;
        ferr_acc <= 1'b0;
      end
      if (shift_en) begin
        shreg    <= {bit_value, shreg[DATA_WIDTH-1:1]};
        data_xor <= data_xor ^ bit_value;
      end
      if (bit_inc)                 bit_cnt  <= bit_cnt + BIT_W'(1);
      if (par_en)                  pbit     <= bit_value;
      if (stop_vote && !bit_value) ferr_acc <= 1'b1;
      if (stop_inc)                stop_cnt <= 1'b1;
    end
  end

  // A commit wins over a same-cycle acceptance; otherwise an accepted word drops valid and its overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= 1'b0;
      word_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      oerr_q <= 1'b0;
    end else if (commit_pend) begin
      if (!data_q || rx.rx_ready) begin
        data_q <= 1'b1;
        word_q <= shreg;
        perr_q <= parity_fail(PARITY_MODE, data_xor, pbit);
        ferr_q <= ferr_acc;
        oerr_q <= 1'b0;
      end else begin
        oerr_q <= 1'b1;
      end
    end else if (data_q && rx.rx_ready) begin
      data_q <= 1'b0;
      oerr_q <= 1'b0;
    end
  end

  assign rx.rx_valid      = data_q;
  assign rx.rx_data       = word_q;
  assign rx.parity_error  = perr_q;
  assign rx.framing_error = ferr_q;
  assign rx.overrun_error = oerr_q;
  assign busy             = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rx_uart_frame_engine.sv
// tb_rx_uart_frame_engine: directed self-checking bench over 8N1, even-parity and two-stop-bit instances.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_rx_uart_frame_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic line_a = 1'b1;
  logic line_p = 1'b1;
  logic line_s = 1'b1;
  logic busy_a, busy_p, busy_s;

  int checks = 0;
  int failures = 0;

  int          acc_cnt = 0;
  int          valid_cycles = 0;
  logic [7:0]  last_data = 8'h00;
  logic        last_perr = 1'b0;
  logic        last_ferr = 1'b0;

  always #5 clk = ~clk;

  rx_uart_frame_engine_if #(.DATA_WIDTH(8)) if_a ();
  rx_uart_frame_engine_if #(.DATA_WIDTH(8)) if_p ();
  rx_uart_frame_engine_if #(.DATA_WIDTH(8)) if_s ();

  rx_uart_frame_engine #(.DATA_WIDTH(8), .OVERSAMPLE(16), .CLK_DIV(1), .PARITY_MODE(0), .STOP_BITS(1))
    dut_a (.clk(clk), .reset(reset), .serial_in_synced(line_a), .busy(busy_a), .rx(if_a));
  rx_uart_frame_engine #(.DATA_WIDTH(8), .OVERSAMPLE(16), .CLK_DIV(1), .PARITY_MODE(1), .STOP_BITS(1))
    dut_p (.clk(clk), .reset(reset), .serial_in_synced(line_p), .busy(busy_p), .rx(if_p));
  rx_uart_frame_engine #(.DATA_WIDTH(8), .OVERSAMPLE(16), .CLK_DIV(1), .PARITY_MODE(0), .STOP_BITS(2))
    dut_s (.clk(clk), .reset(reset), .serial_in_synced(line_s), .busy(busy_s), .rx(if_s));

  // Handshake monitor for the 8N1 instance, sampled mid-cycle after stimulus has settled.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (if_a.rx_valid) valid_cycles <= valid_cycles + 1;
      if (if_a.rx_valid && if_a.rx_ready) begin
        acc_cnt   <= acc_cnt + 1;
        last_data <= if_a.rx_data;
        last_perr <= if_a.parity_error;
        last_ferr <= if_a.framing_error;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input int sel, input logic v);
    case (sel)
      0:       line_a = v;
      1:       line_p = v;
      default: line_s = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // bits[0] is the start bit; each bit lasts 16 clks, index 'spike' within every bit is inverted.
  task automatic send(input int sel, input logic [15:0] bits, input int nbits, input int spike);
    logic v;
    for (int b = 0; b < nbits; b++) begin
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        v = bits[b];
        if (j == spike) v = ~v;
        drive(sel, v);
      end
    end
    @(negedge clk);
    drive(sel, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_a.rx_ready = 1'b1;
    if_p.rx_ready = 1'b0;
    if_s.rx_ready = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(2);
    checks++;
    if ({if_a.rx_valid, if_a.parity_error, if_a.framing_error, if_a.overrun_error, busy_a, busy_p, busy_s} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000000",
               {if_a.rx_valid, if_a.parity_error, if_a.framing_error, if_a.overrun_error, busy_a, busy_p, busy_s});
    end
    checks++;
    if (if_a.rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", if_a.rx_data); end
  endtask

  task automatic test_basic();
    int c0 = acc_cnt;
    int v0 = valid_cycles;
    send(0, {6'h3F, 1'b1, 8'hA5, 1'b0}, 10, -1);
    idle(4);
    checks++;
    if (acc_cnt !== c0 + 1) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", acc_cnt, c0 + 1); end
    checks++;
    if (valid_cycles !== v0 + 1) begin failures++; $display("FAIL basic_valid_len got=%0d exp=%0d", valid_cycles, v0 + 1); end
    checks++;
    if (last_data !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", last_data); end
    checks++;
    if ({last_perr, last_ferr, if_a.overrun_error} !== 3'b000) begin
      failures++; $display("FAIL basic_flags got=%b exp=000", {last_perr, last_ferr, if_a.overrun_error});
    end
    checks++;
    if ({if_a.rx_valid, busy_a} !== 2'b00) begin failures++; $display("FAIL basic_idle got=%b exp=00", {if_a.rx_valid, busy_a}); end
  endtask

  task automatic test_parity();
    logic exp_perr [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      send(1, {5'h1F, 1'b1, 1'(k), 8'h07, 1'b0}, 11, -1);
      idle(2);
      checks++;
      if ({if_p.rx_valid, if_p.rx_data} !== {1'b1, 8'h07}) begin
        failures++; $display("FAIL parity_word%0d got=%b/%h exp=1/07", k, if_p.rx_valid, if_p.rx_data);
      end
      checks++;
      if ({if_p.parity_error, if_p.framing_error} !== {exp_perr[k], 1'b0}) begin
        failures++; $display("FAIL parity_flags%0d got=%b exp=%b0", k, {if_p.parity_error, if_p.framing_error}, exp_perr[k]);
      end
      @(negedge clk); if_p.rx_ready = 1'b1;
      @(negedge clk); if_p.rx_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (if_p.rx_valid !== 1'b0) begin failures++; $display("FAIL parity_accept%0d got=%b exp=0", k, if_p.rx_valid); end
    end
  endtask

  task automatic test_glitch();
    int c0 = acc_cnt;
    int v0 = valid_cycles;
    @(negedge clk); line_a = 1'b0;
    idle(2);
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise got=%b exp=1", busy_a); end
    @(negedge clk); line_a = 1'b1;
    idle(30);
    checks++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL glitch_busy_fall got=%b exp=0", busy_a); end
    checks++;
    if (acc_cnt !== c0 || valid_cycles !== v0) begin
      failures++; $display("FAIL glitch_no_word got=%0d/%0d exp=%0d/%0d", acc_cnt, valid_cycles, c0, v0);
    end
  endtask

  task automatic test_overrun();
    int c0 = acc_cnt;
    if_a.rx_ready = 1'b0;
    send(0, {6'h3F, 1'b1, 8'h11, 1'b0}, 10, -1);
    idle(20);
    send(0, {6'h3F, 1'b1, 8'h22, 1'b0}, 10, -1);
    idle(4);
    checks++;
    if ({if_a.rx_valid, if_a.rx_data} !== {1'b1, 8'h11}) begin
      failures++; $display("FAIL overrun_held got=%b/%h exp=1/11", if_a.rx_valid, if_a.rx_data);
    end
    checks++;
    if (if_a.overrun_error !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", if_a.overrun_error); end
    @(negedge clk); if_a.rx_ready = 1'b1;
    @(negedge clk); if_a.rx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_a.rx_valid, if_a.overrun_error} !== 2'b00) begin
      failures++; $display("FAIL overrun_clear got=%b exp=00", {if_a.rx_valid, if_a.overrun_error});
    end
    checks++;
    if (acc_cnt !== c0 + 1 || last_data !== 8'h11) begin
      failures++; $display("FAIL overrun_accepted got=%0d/%h exp=%0d/11", acc_cnt, last_data, c0 + 1);
    end
    if_a.rx_ready = 1'b1;
  endtask

  task automatic test_stop2();
    logic [7:0] word  [2] = '{8'h3C, 8'hC3};
    logic       stop2 [2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      send(2, {5'h1F, stop2[k], 1'b1, word[k], 1'b0}, 11, -1);
      idle(2);
      checks++;
      if ({if_s.rx_valid, if_s.rx_data} !== {1'b1, word[k]}) begin
        failures++; $display("FAIL stop2_word%0d got=%b/%h exp=1/%h", k, if_s.rx_valid, if_s.rx_data, word[k]);
      end
      checks++;
      if ({if_s.framing_error, if_s.parity_error} !== {~stop2[k], 1'b0}) begin
        failures++; $display("FAIL stop2_flags%0d got=%b exp=%b0", k, {if_s.framing_error, if_s.parity_error}, ~stop2[k]);
      end
      @(negedge clk); if_s.rx_ready = 1'b1;
      @(negedge clk); if_s.rx_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int c0 = acc_cnt;
    send(0, {6'h3F, 1'b1, 8'h5A, 1'b0}, 4, -1);
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL rstmid_busy got=%b exp=1", busy_a); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    idle(200);
    checks++;
    if ({busy_a, if_a.rx_valid} !== 2'b00 || acc_cnt !== c0) begin
      failures++; $display("FAIL rstmid_discard got=%b/%0d exp=00/%0d", {busy_a, if_a.rx_valid}, acc_cnt, c0);
    end
    send(0, {6'h3F, 1'b1, 8'h5A, 1'b0}, 10, -1);
    idle(4);
    checks++;
    if (acc_cnt !== c0 + 1 || last_data !== 8'h5A) begin
      failures++; $display("FAIL rstmid_word got=%0d/%h exp=%0d/5a", acc_cnt, last_data, c0 + 1);
    end
    checks++;
    if ({last_perr, last_ferr} !== 2'b00) begin failures++; $display("FAIL rstmid_flags got=%b exp=00", {last_perr, last_ferr}); end
  endtask

  task automatic test_spike();
    logic [7:0] word  [3] = '{8'h96, 8'h4B, 8'h2D};
    int         spike [3] = '{9, 8, 10};
    for (int k = 0; k < 3; k++) begin
      int c0 = acc_cnt;
      send(0, {6'h3F, 1'b1, word[k], 1'b0}, 10, spike[k]);
      idle(4);
      checks++;
      if (acc_cnt !== c0 + 1 || last_data !== word[k] || last_ferr !== 1'b0) begin
        failures++;
        $display("FAIL spike%0d got=%0d/%h/%b exp=%0d/%h/0", k, acc_cnt, last_data, last_ferr, c0 + 1, word[k]);
      end
    end
  endtask

  task automatic test_break();
    int c0 = acc_cnt;
    @(negedge clk); line_a = 1'b0;
    idle(192);
    checks++;
    if (acc_cnt !== c0 + 1 || last_data !== 8'h00) begin
      failures++; $display("FAIL break_word got=%0d/%h exp=%0d/00", acc_cnt, last_data, c0 + 1);
    end
    checks++;
    if (last_ferr !== 1'b1) begin failures++; $display("FAIL break_ferr got=%b exp=1", last_ferr); end
    checks++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL break_busy got=%b exp=0", busy_a); end
    line_a = 1'b1;
    idle(40);
    checks++;
    if (acc_cnt !== c0 + 1) begin failures++; $display("FAIL break_single got=%0d exp=%0d", acc_cnt, c0 + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_overrun();
    test_stop2();
    test_reset_mid();
    test_spike();
    test_break();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
